// File: rtl/popcount_pkg.sv
// Shared definitions for the popcount pipeline: mode encodings, frame FSM states
// and the helper that sizes count buses.
package popcount_pkg;

    localparam logic MODE_WORD  = 1'b0;
    localparam logic MODE_FRAME = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } frame_state_t;

    // Bits needed to hold a count of 0..n ones.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational population count of one CHUNK-bit slice.
module popcount_chunk
    import popcount_pkg::*;
#(
    parameter int CHUNK = 8,
    localparam int CW   = count_width(CHUNK)
) (
    input  logic [CHUNK-1:0] bits,
    output logic [CW-1:0]    count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/popcount_pipe.sv
// Three-stage popcount pipeline: chunk counts, chunk sum, then a per-word
// output register or a saturating per-frame accumulator, all under one stall.
module popcount_pipe
    import popcount_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_count,
    output logic             out_sat
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = count_width(CHUNK);
    localparam int SW     = count_width(WIDTH);
    localparam logic [ACC_W:0] ACC_MAX = {1'b0, {ACC_W{1'b1}}};

    if (WIDTH < 2) begin : g_bad_width
        $error("popcount_pipe: WIDTH must be at least 2");
    end
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("popcount_pipe: WIDTH must be a multiple of CHUNK");
    end
    if (ACC_W < SW) begin : g_bad_acc_w
        $error("popcount_pipe: ACC_W too narrow to hold a full-word count");
    end

    logic advance;

    // Stage 1 state
    logic [CW-1:0] chunk_cnt  [NCHUNK];
    logic [CW-1:0] s1_cnt_reg [NCHUNK];
    logic          s1_valid_reg;
    logic          s1_mode_reg;
    logic          s1_last_reg;

    // Stage 2 state
    logic [SW-1:0] chunk_sum;
    logic [SW-1:0] s2_sum_reg;
    logic          s2_valid_reg;
    logic          s2_mode_reg;
    logic          s2_last_reg;

    // Stage 3 state
    frame_state_t     state_reg;
    logic             mode_reg;
    logic [ACC_W-1:0] acc_reg;
    logic             sat_reg;
    logic             out_valid_reg;
    logic [ACC_W-1:0] out_count_reg;
    logic             out_sat_reg;

    logic             eff_mode;
    logic [ACC_W:0]   sum_ext;
    logic             over;
    logic [ACC_W-1:0] acc_next;
    logic             sat_next;

    // The whole pipe moves together; only a held result blocks it.
    assign advance  = !out_valid_reg || out_ready;
    assign in_ready = advance;

    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
        popcount_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .bits  (in_data[gi*CHUNK +: CHUNK]),
            .count (chunk_cnt[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_mode_reg  <= MODE_WORD;
            s1_last_reg  <= 1'b0;
            for (int i = 0; i < NCHUNK; i++) begin
                s1_cnt_reg[i] <= '0;
            end
        end else if (advance) begin
            s1_valid_reg <= in_valid;
            s1_mode_reg  <= in_mode;
            s1_last_reg  <= in_last;
            for (int i = 0; i < NCHUNK; i++) begin
                s1_cnt_reg[i] <= chunk_cnt[i];
            end
        end
    end

    always_comb begin
        chunk_sum = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            chunk_sum = chunk_sum + SW'(s1_cnt_reg[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            s2_sum_reg   <= '0;
            s2_mode_reg  <= MODE_WORD;
            s2_last_reg  <= 1'b0;
        end else if (advance) begin
            s2_valid_reg <= s1_valid_reg;
            s2_sum_reg   <= chunk_sum;
            s2_mode_reg  <= s1_mode_reg;
            s2_last_reg  <= s1_last_reg;
        end
    end

    // An open frame keeps the mode captured on its first beat.
    always_comb begin
        eff_mode = (state_reg == ST_ACCUM) ? mode_reg : s2_mode_reg;
        sum_ext  = {1'b0, acc_reg} + (ACC_W + 1)'(s2_sum_reg);
        over     = (sum_ext > ACC_MAX);
        acc_next = over ? '1 : sum_ext[ACC_W-1:0];
        sat_next = sat_reg | over;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            mode_reg      <= MODE_WORD;
            acc_reg       <= '0;
            sat_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
            out_count_reg <= '0;
            out_sat_reg   <= 1'b0;
        end else if (advance) begin
            out_valid_reg <= 1'b0;
            if (s2_valid_reg) begin
                if (state_reg == ST_IDLE) begin
                    mode_reg <= s2_mode_reg;
                end
                if (eff_mode == MODE_WORD) begin
                    out_valid_reg <= 1'b1;
                    out_count_reg <= ACC_W'(s2_sum_reg);
                    out_sat_reg   <= 1'b0;
                end else if (s2_last_reg) begin
                    out_valid_reg <= 1'b1;
                    out_count_reg <= acc_next;
                    out_sat_reg   <= sat_next;
                    acc_reg       <= '0;
                    sat_reg       <= 1'b0;
                    state_reg     <= ST_IDLE;
                end else begin
                    acc_reg   <= acc_next;
                    sat_reg   <= sat_next;
                    state_reg <= ST_ACCUM;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_count = out_count_reg;
    assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_popcount_pipe.sv
// Directed bench for popcount_pipe: a default instance and a narrow ACC_W=6
// instance share one stimulus stream so the saturation path can be observed.
module tb_popcount_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_mode;
    logic        in_last;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_count;
    logic        out_sat;

    logic        in_ready6;
    logic        out_valid6;
    logic [5:0]  out_count6;
    logic        out_sat6;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    popcount_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    popcount_pipe #(
        .ACC_W (6)
    ) dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready6),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_last   (in_last),
        .out_valid (out_valid6),
        .out_ready (out_ready),
        .out_count (out_count6),
        .out_sat   (out_sat6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] data, input logic mode, input logic last);
        in_valid = 1'b1;
        in_data  = data;
        in_mode  = mode;
        in_last  = last;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 32'h0;
        in_last  = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] cnt, input logic sat);
        $display("[%0t] %s: valid=%0b count=%0d sat=%0b in_ready=%0b",
                 $time, tag, out_valid, out_count, out_sat, in_ready);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            check({tag, "_count"}, 32'(out_count), cnt);
            check({tag, "_sat"}, 32'(out_sat), 32'(sat));
        end
    endtask

    task automatic expect_out6(input string tag, input logic v, input logic [31:0] cnt, input logic sat);
        $display("[%0t] %s: valid=%0b count=%0d sat=%0b (ACC_W=6)",
                 $time, tag, out_valid6, out_count6, out_sat6);
        check({tag, "_valid6"}, 32'(out_valid6), 32'(v));
        if (v) begin
            check({tag, "_count6"}, 32'(out_count6), cnt);
            check({tag, "_sat6"}, 32'(out_sat6), 32'(sat));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_mode   = 1'b0;
        idle();

        // Reset state
        repeat (3) tick();
        expect_out("rst", 1'b0, 32'd0, 1'b0);
        check("rst_count", 32'(out_count), 32'd0);
        check("rst_sat", 32'(out_sat), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        expect_out("post_rst", 1'b0, 32'd0, 1'b0);

        // All-ones word, latency of three cycles
        beat(32'hFFFF_FFFF, 1'b0, 1'b0);
        tick();
        idle();
        expect_out("lat_c1", 1'b0, 32'd0, 1'b0);
        tick();
        expect_out("lat_c2", 1'b0, 32'd0, 1'b0);
        tick();
        expect_out("lat_c3", 1'b1, 32'd32, 1'b0);
        expect_out6("lat_c3", 1'b1, 32'd32, 1'b0);
        tick();
        expect_out("lat_drain", 1'b0, 32'd0, 1'b0);

        // Back-to-back words
        beat(32'h0000_0000, 1'b0, 1'b0);
        tick();
        beat(32'hAAAA_AAAA, 1'b0, 1'b0);
        tick();
        beat(32'h0000_0001, 1'b0, 1'b0);
        tick();
        idle();
        expect_out("b2b_0", 1'b1, 32'd0, 1'b0);
        tick();
        expect_out("b2b_1", 1'b1, 32'd16, 1'b0);
        tick();
        expect_out("b2b_2", 1'b1, 32'd1, 1'b0);
        tick();
        expect_out("b2b_drain", 1'b0, 32'd0, 1'b0);

        // Output stall for four cycles with 16 pending
        beat(32'hAAAA_AAAA, 1'b0, 1'b0);
        tick();
        beat(32'h0000_0003, 1'b0, 1'b0);
        tick();
        out_ready = 1'b0;
        beat(32'h0000_0007, 1'b0, 1'b0);
        tick();
        beat(32'h0000_000F, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            expect_out("stall_hold", 1'b1, 32'd16, 1'b0);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            if (k != 3) tick();
        end
        out_ready = 1'b1;
        tick();
        idle();
        expect_out("stall_rel_0", 1'b1, 32'd2, 1'b0);
        tick();
        expect_out("stall_rel_1", 1'b1, 32'd3, 1'b0);
        tick();
        expect_out("stall_rel_2", 1'b1, 32'd4, 1'b0);
        tick();
        expect_out("stall_drain", 1'b0, 32'd0, 1'b0);

        // Frame with a bubble; in_mode drops mid-frame and must be ignored
        beat(32'hFFFF_FFFF, 1'b1, 1'b0);
        tick();
        idle();
        expect_out("frm_e0", 1'b0, 32'd0, 1'b0);
        tick();
        beat(32'hAAAA_AAAA, 1'b0, 1'b0);
        expect_out("frm_e1", 1'b0, 32'd0, 1'b0);
        tick();
        beat(32'h0000_0001, 1'b0, 1'b1);
        expect_out("frm_e2", 1'b0, 32'd0, 1'b0);
        tick();
        idle();
        expect_out("frm_e3", 1'b0, 32'd0, 1'b0);
        tick();
        expect_out("frm_e4", 1'b0, 32'd0, 1'b0);
        tick();
        expect_out("frm_res", 1'b1, 32'd49, 1'b0);
        expect_out6("frm_res", 1'b1, 32'd49, 1'b0);
        tick();
        expect_out("frm_drain", 1'b0, 32'd0, 1'b0);

        // Saturating frame on the narrow instance, then a single-beat frame
        beat(32'hFFFF_FFFF, 1'b1, 1'b0);
        tick();
        beat(32'hFFFF_FFFF, 1'b1, 1'b0);
        tick();
        beat(32'hFFFF_FFFF, 1'b1, 1'b1);
        tick();
        beat(32'h0000_000F, 1'b1, 1'b1);
        tick();
        idle();
        expect_out("sat_e3", 1'b0, 32'd0, 1'b0);
        tick();
        expect_out6("sat_res", 1'b1, 32'd63, 1'b1);
        expect_out("sat_res_wide", 1'b1, 32'd96, 1'b0);
        tick();
        expect_out6("sat_next", 1'b1, 32'd4, 1'b0);
        expect_out("sat_next_wide", 1'b1, 32'd4, 1'b0);
        tick();
        expect_out("sat_drain", 1'b0, 32'd0, 1'b0);

        // Reset in the middle of an open frame
        beat(32'hFFFF_FFFF, 1'b1, 1'b0);
        tick();
        beat(32'hFFFF_FFFF, 1'b1, 1'b0);
        tick();
        idle();
        repeat (3) tick();
        expect_out("open_frame", 1'b0, 32'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(out_count), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        expect_out("mid_rst", 1'b0, 32'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        beat(32'h0000_00FF, 1'b1, 1'b1);
        tick();
        idle();
        expect_out("after_rst_c1", 1'b0, 32'd0, 1'b0);
        tick();
        expect_out("after_rst_c2", 1'b0, 32'd0, 1'b0);
        tick();
        expect_out("after_rst_res", 1'b1, 32'd8, 1'b0);
        expect_out6("after_rst_res", 1'b1, 32'd8, 1'b0);
        tick();
        expect_out("after_rst_drain", 1'b0, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
